// File: rtl/nios2_c_tcm_dual_port_ram.sv
// Dual-port tightly-coupled data RAM with byte enables, a shared stall line and
// an optional post-reset zero-fill that sweeps one word per cycle.
module nios2_c_tcm_dual_port_ram #(
    parameter int DATA_WIDTH     = 32,
    parameter int DEPTH          = 20000,
    parameter int ADDR_WIDTH     = 15,
    parameter int READ_LATENCY   = 1,
    parameter int CLEAR_ON_RESET = 1
) (
    input  logic                    clk,
    input  logic                    reset_n,
    input  logic [ADDR_WIDTH-1:0]   address,
    input  logic [DATA_WIDTH/8-1:0] byteenable,
    input  logic                    chipselect,
    input  logic                    read,
    input  logic                    write,
    input  logic [DATA_WIDTH-1:0]   writedata,
    output logic [DATA_WIDTH-1:0]   readdata,
    output logic                    readdatavalid,
    input  logic [ADDR_WIDTH-1:0]   address2,
    input  logic [DATA_WIDTH/8-1:0] byteenable2,
    input  logic                    chipselect2,
    input  logic                    read2,
    input  logic                    write2,
    input  logic [DATA_WIDTH-1:0]   writedata2,
    output logic [DATA_WIDTH-1:0]   readdata2,
    output logic                    readdatavalid2,
    output logic                    waitrequest
);

    localparam int NB    = DATA_WIDTH / 8;
    localparam int IDX_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam logic [IDX_W-1:0] LAST_WORD = IDX_W'(DEPTH - 1);

    typedef enum logic {
        CLEAR = 1'b0,
        READY = 1'b1
    } state_t;

    state_t              r_state;
    state_t              w_state_next;
    logic [IDX_W-1:0]    r_clr_cnt;
    logic [DATA_WIDTH-1:0] r_mem [DEPTH];

    logic [1:0]            w_cs, w_rd, w_wr, w_wr_acc, w_rd_acc, w_in_range, w_rvld;
    logic [ADDR_WIDTH-1:0] w_addr  [2];
    logic [IDX_W-1:0]      w_idx   [2];
    logic [NB-1:0]         w_be    [2];
    logic [DATA_WIDTH-1:0] w_wdata [2];
    logic [DATA_WIDTH-1:0] w_rdata [2];

    assign w_cs       = {chipselect2, chipselect};
    assign w_rd       = {read2, read};
    assign w_wr       = {write2, write};
    assign w_addr[0]  = address;
    assign w_addr[1]  = address2;
    assign w_be[0]    = byteenable;
    assign w_be[1]    = byteenable2;
    assign w_wdata[0] = writedata;
    assign w_wdata[1] = writedata2;

    assign waitrequest    = (r_state == CLEAR);
    assign readdata       = w_rdata[0];
    assign readdata2      = w_rdata[1];
    assign readdatavalid  = w_rvld[0];
    assign readdatavalid2 = w_rvld[1];

    always_comb begin
        w_state_next = r_state;
        if (r_state == CLEAR && r_clr_cnt == LAST_WORD) begin
            w_state_next = READY;
        end
    end

    always_ff @(posedge clk) begin
        if (!reset_n) begin
            r_state   <= (CLEAR_ON_RESET != 0) ? CLEAR : READY;
            r_clr_cnt <= '0;
        end else begin
            r_state <= w_state_next;
            if (r_state == CLEAR) begin
                r_clr_cnt <= r_clr_cnt + 1'b1;
            end
        end
    end

    // Port B is applied before port A so A's lanes win on a same-address collision.
    always_ff @(posedge clk) begin
        if (reset_n) begin
            if (r_state == CLEAR) begin
                r_mem[r_clr_cnt] <= '0;
            end else begin
                for (int p = 1; p >= 0; p--) begin
                    if (w_wr_acc[p] && w_in_range[p]) begin
                        for (int b = 0; b < NB; b++) begin
                            if (w_be[p][b]) begin
                                r_mem[w_idx[p]][8*b +: 8] <= w_wdata[p][8*b +: 8];
                            end
                        end
                    end
                end
            end
        end
    end

    for (genvar gi = 0; gi < 2; gi++) begin : g_port
        logic [DATA_WIDTH-1:0] w_fwd_data, w_merged, r_raw, r_fwd_data, r_hold;
        logic [NB-1:0]         w_fwd_mask, r_fwd_mask;
        logic                  r_vld, r_oor;

        assign w_in_range[gi] = (32'(w_addr[gi]) < 32'(DEPTH));
        assign w_idx[gi]      = w_addr[gi][IDX_W-1:0];
        assign w_wr_acc[gi]   = w_cs[gi] & w_wr[gi] & ~waitrequest;
        assign w_rd_acc[gi]   = w_cs[gi] & w_rd[gi] & ~w_wr[gi] & ~waitrequest;

        // Lanes written this same cycle override the (pre-write) RAM word.
        always_comb begin
            w_fwd_data = '0;
            w_fwd_mask = '0;
            for (int p = 1; p >= 0; p--) begin
                if (w_wr_acc[p] && w_addr[p] == w_addr[gi]) begin
                    for (int b = 0; b < NB; b++) begin
                        if (w_be[p][b]) begin
                            w_fwd_data[8*b +: 8] = w_wdata[p][8*b +: 8];
                            w_fwd_mask[b]        = 1'b1;
                        end
                    end
                end
            end
        end

        always_ff @(posedge clk) begin
            if (w_rd_acc[gi] && w_in_range[gi]) begin
                r_raw <= r_mem[w_idx[gi]];
            end
        end

        always_ff @(posedge clk) begin
            if (!reset_n) begin
                r_vld      <= 1'b0;
                r_oor      <= 1'b0;
                r_fwd_mask <= '0;
                r_fwd_data <= '0;
            end else begin
                r_vld      <= w_rd_acc[gi];
                r_oor      <= ~w_in_range[gi];
                r_fwd_mask <= w_fwd_mask;
                r_fwd_data <= w_fwd_data;
            end
        end

        always_comb begin
            w_merged = '0;
            if (!r_oor) begin
                for (int b = 0; b < NB; b++) begin
                    w_merged[8*b +: 8] = r_fwd_mask[b] ? r_fwd_data[8*b +: 8] : r_raw[8*b +: 8];
                end
            end
        end

        always_ff @(posedge clk) begin
            if (!reset_n) begin
                r_hold <= '0;
            end else if (r_vld) begin
                r_hold <= w_merged;
            end
        end

        if (READ_LATENCY == 1) begin : g_lat1
            assign w_rdata[gi] = r_vld ? w_merged : r_hold;
            assign w_rvld[gi]  = r_vld;
        end else begin : g_lat2
            logic r_vld2;
            always_ff @(posedge clk) begin
                if (!reset_n) begin
                    r_vld2 <= 1'b0;
                end else begin
                    r_vld2 <= r_vld;
                end
            end
            assign w_rdata[gi] = r_hold;
            assign w_rvld[gi]  = r_vld2;
        end
    end

endmodule
